// File: rtl/sw_led_pkg.sv
// Shared constants and helpers for the switch/LED controller.
// Mode encodings and the counter-width rule used by every sizing decision.
package sw_led_pkg;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_TOGGLE = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  // A counter spanning 0..n-1 needs $clog2(n) bits, but never fewer than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sw_led_ctrl_debounce.sv
// One-bit switch conditioner: two-flop synchroniser, saturating-free debounce
// counter, accepted value db and a one-cycle rise pulse registered with db.
module sw_debounce
  import sw_led_pkg::*;
#(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic db,
  output logic rise
);

  localparam int CW = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          db_q, db_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    s1_d   = sw_in;
    s2_d   = s1_q;
    db_d   = db_q;
    cnt_d  = cnt_q;
    rise_d = 1'b0;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Disagreement has persisted long enough: accept it and restart.
      db_d   = s2_q;
      cnt_d  = '0;
      rise_d = s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign db   = db_q;
  assign rise = rise_q;

endmodule

// File: rtl/sw_led_ctrl.sv
// Switch-to-LED controller: per-bit debouncers feeding a four-mode LED driver
// (pass-through, toggle, chase, blink) paced by a free-running tick.
module sw_led_ctrl
  import sw_led_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DB_CYCLES   = 4,
  parameter int TICK_CYCLES = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] SW,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] LED
);

  localparam int TW = cnt_width(TICK_CYCLES);
  localparam logic [TW-1:0] TC_MAX = TW'(TICK_CYCLES - 1);

  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] rise;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_db
    sw_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .sw_in(SW[gi]),
      .db   (db[gi]),
      .rise (rise[gi])
    );
  end

  logic [TW-1:0]    tc_q, tc_d;
  logic             phase_q, phase_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] led_q, led_d;
  logic             tick;
  logic             mode_entry;
  logic [WIDTH-1:0] rot_left, rot_right;

  always_comb begin
    tick    = (tc_q == TC_MAX);
    tc_d    = tick ? '0 : tc_q + TW'(1);
    phase_d = phase_q ^ tick;
    mode_d  = mode;
  end

  // Shift-based rotates degrade gracefully to identity when WIDTH is 1.
  always_comb begin
    rot_left  = (led_q << 1) | (led_q >> (WIDTH - 1));
    rot_right = (led_q >> 1) | (led_q << (WIDTH - 1));
  end

  always_comb begin
    mode_entry = (mode != mode_q);
    led_d      = led_q;
    case (mode)
      MODE_PASS:   led_d = db;
      MODE_TOGGLE: led_d = led_q ^ rise;
      MODE_CHASE: begin
        if (mode_entry) begin
          led_d = WIDTH'(1);
        end else if (tick) begin
          led_d = db[0] ? rot_right : rot_left;
        end
      end
      // Uses the post-tick phase so the blink edge coincides with the tick edge.
      MODE_BLINK:  led_d = phase_d ? db : '0;
      default:     led_d = led_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tc_q    <= '0;
      phase_q <= 1'b0;
      mode_q  <= MODE_PASS;
      led_q   <= '0;
    end else begin
      tc_q    <= tc_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
    end
  end

  assign LED = led_q;

endmodule

// File: tb/tb_sw_led_ctrl.sv
// Directed bench for sw_led_ctrl: a table of pass-through vectors plus
// hand-written sequences for bounce, toggle, chase, blink and reset corners.
module tb_sw_led_ctrl;

  logic       clk;
  logic       reset;
  logic [7:0] SW;
  logic [1:0] mode;
  logic [7:0] LED;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference tick/phase, derived only from reset and the clock.
  int   tb_tc    = 0;
  logic tb_phase = 1'b0;

  sw_led_ctrl #(
    .WIDTH      (8),
    .DB_CYCLES  (4),
    .TICK_CYCLES(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .SW   (SW),
    .mode (mode),
    .LED  (LED)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) begin
      tb_tc    <= 0;
      tb_phase <= 1'b0;
    end else begin
      tb_tc    <= (tb_tc == 7) ? 0 : tb_tc + 1;
      tb_phase <= (tb_tc == 7) ? ~tb_phase : tb_phase;
    end
  end

  typedef struct {
    logic [7:0] sw;
    int         edges;
    logic [7:0] exp_led;
  } vec_t;

  vec_t vecs[6];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: LED=%h required=%h t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: LED=%h t=%0t", name, act, $time);
    end
  endtask

  task automatic wait_pre_tick();
    int g;
    g = 0;
    while (tb_tc != 7 && g < 20) begin
      step(1);
      g++;
    end
  endtask

  initial begin
    logic [7:0] exp;
    int g;

    // Pass-through vectors applied from a settled LED=FF state.
    vecs[0] = '{sw: 8'h00, edges: 6, exp_led: 8'hFF};
    vecs[1] = '{sw: 8'h00, edges: 1, exp_led: 8'h00};
    vecs[2] = '{sw: 8'h5A, edges: 7, exp_led: 8'h5A};
    vecs[3] = '{sw: 8'hC3, edges: 6, exp_led: 8'h5A};
    vecs[4] = '{sw: 8'hC3, edges: 1, exp_led: 8'hC3};
    vecs[5] = '{sw: 8'h00, edges: 8, exp_led: 8'h00};

    // Reset then PASS.
    reset = 1'b1;
    mode  = 2'd0;
    SW    = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      step(1);
      check("reset_hold", LED, 8'h00);
    end
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check("pass_latency_wait", LED, 8'h00);
    end
    step(1);
    check("pass_latency_edge7", LED, 8'hFF);

    for (int v = 0; v < 6; v++) begin
      SW = vecs[v].sw;
      step(vecs[v].edges);
      check($sformatf("pass_vec%0d", v), LED, vecs[v].exp_led);
    end

    // Bounce rejection on bit 0.
    for (int k = 0; k < 6; k++) begin
      SW[0] = (k % 2 == 0);
      for (int j = 0; j < 2; j++) begin
        step(1);
        check("bounce_reject", LED, 8'h00);
      end
    end
    SW[0] = 1'b1;
    step(6);
    check("bounce_settle_wait", LED, 8'h00);
    step(1);
    check("bounce_settle_edge7", LED, 8'h01);

    // Toggle on bit 3.
    mode = 2'd1;
    step(1);
    check("toggle_entry_keeps", LED, 8'h01);
    SW = 8'h09;
    step(6);
    check("toggle_rise_wait", LED, 8'h01);
    step(1);
    check("toggle_rise_edge7", LED, 8'h09);
    step(3);
    SW = 8'h01;
    step(10);
    check("toggle_fall_ignored", LED, 8'h09);
    SW = 8'h09;
    step(6);
    check("toggle_rise2_wait", LED, 8'h09);
    step(1);
    check("toggle_rise2_edge7", LED, 8'h01);
    step(3);
    SW = 8'h01;
    step(10);
    check("toggle_fall2_ignored", LED, 8'h01);
    SW = 8'h09;
    step(3);
    SW = 8'h01;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("toggle_glitch3_rejected", LED, 8'h01);
    end
    SW = 8'h09;
    step(4);
    SW = 8'h01;
    step(2);
    check("toggle_pulse4_wait", LED, 8'h01);
    step(1);
    check("toggle_pulse4_accepted", LED, 8'h09);
    SW = 8'h00;
    step(8);
    check("toggle_fall3_ignored", LED, 8'h09);

    // Chase left with SW[0]=0, then right with SW[0]=1.
    mode = 2'd2;
    step(1);
    check("chase_entry", LED, 8'h01);
    exp = 8'h01;
    for (int r = 0; r < 8; r++) begin
      wait_pre_tick();
      check("chase_hold", LED, exp);
      step(1);
      exp = {exp[6:0], exp[7]};
      check("chase_left", LED, exp);
    end
    SW = 8'h01;
    wait_pre_tick();
    step(1);
    check("chase_right_wrap", LED, 8'h80);
    wait_pre_tick();
    check("chase_right_hold", LED, 8'h80);
    step(1);
    check("chase_right", LED, 8'h40);

    // Blink with SW=A5.
    SW = 8'hA5;
    step(8);
    mode = 2'd3;
    step(1);
    check("blink_entry", LED, tb_phase ? 8'hA5 : 8'h00);
    for (int r = 0; r < 4; r++) begin
      wait_pre_tick();
      check("blink_hold", LED, tb_phase ? 8'hA5 : 8'h00);
      step(1);
      check("blink_tick", LED, tb_phase ? 8'hA5 : 8'h00);
    end

    // Chase entry on a tick edge: entry wins over rotation.
    wait_pre_tick();
    mode = 2'd2;
    step(1);
    check("chase_entry_on_tick", LED, 8'h01);

    // Reset mid-chase when LED=10.
    SW = 8'h00;
    step(8);
    g = 0;
    while (LED !== 8'h10 && g < 200) begin
      step(1);
      g++;
    end
    check("chase_reach_10", LED, 8'h10);
    reset = 1'b1;
    step(1);
    check("midreset_clear", LED, 8'h00);
    reset = 1'b0;
    step(1);
    check("midreset_reentry", LED, 8'h01);
    for (int k = 2; k <= 7; k++) begin
      step(1);
      check("midreset_hold", LED, 8'h01);
    end
    step(1);
    check("midreset_first_rot", LED, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
